// File: rtl/isa_pkg.sv
// isa_pkg: shared ISA definitions for the fetch/decode front end.
//   fmt_e    - instruction format (C/I/M/X), encoded as presented on `format`
//   opcode_e - 4-bit opcode names, LB (0) .. BLS (F)
//   state_e  - fetch controller states
//   dec_t    - decoded instruction fields, excluding the PC_W-wide jump target
//   fmt_of() - opcode -> format map
package isa_pkg;

    typedef enum logic [1:0] {
        FMT_C = 2'b00,
        FMT_I = 2'b01,
        FMT_M = 2'b10,
        FMT_X = 2'b11
    } fmt_e;

    typedef enum logic [3:0] {
        OP_LB   = 4'h0,
        OP_SB   = 4'h1,
        OP_JMP  = 4'h2,
        OP_CMP  = 4'h3,
        OP_BR   = 4'h4,
        OP_MVB  = 4'h5,
        OP_AND  = 4'h6,
        OP_ADD  = 4'h7,
        OP_SUB  = 4'h8,
        OP_DEC  = 4'h9,
        OP_OR   = 4'hA,
        OP_XOR  = 4'hB,
        OP_SHL  = 4'hC,
        OP_INC  = 4'hD,
        OP_HALT = 4'hE,
        OP_BLS  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    typedef struct packed {
        fmt_e       fmt;
        logic [3:0] opcode;
        logic [2:0] reg1_i;
        logic [2:0] reg2_i;
        logic [2:0] reg_o;
        logic [2:0] imm;
        logic       imm_flag;
    } dec_t;

    // Returned for any fetch beyond the end of instruction memory.
    localparam logic [7:0] HALT_INSTR = 8'hE0;

    function automatic fmt_e fmt_of(input logic [3:0] op);
        case (op)
            OP_JMP, OP_BR:  return FMT_C;
            OP_DEC, OP_INC: return FMT_I;
            OP_HALT:        return FMT_X;
            default:        return FMT_M;
        endcase
    endfunction

endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational decode of one instruction byte.
//   instr    in  8               raw instruction byte
//   labels   in  NLABELS x PC_W  jump-label table
//   dec      out dec_t           format, opcode, register indices, imm fields
//   jmp_loc  out PC_W            label-table target (0 for I and X forms)
import isa_pkg::*;

module instr_decode #(
    parameter int PC_W    = 16,
    parameter int NLABELS = 16
) (
    input  logic [7:0]                     instr,
    input  logic [NLABELS-1:0][PC_W-1:0]   labels,
    output dec_t                           dec,
    output logic [PC_W-1:0]                jmp_loc
);

    fmt_e f;

    always_comb begin
        f            = fmt_of(instr[7:4]);
        dec          = '0;
        jmp_loc      = '0;
        dec.fmt      = f;
        dec.opcode   = instr[7:4];
        dec.imm      = instr[3:1];
        dec.imm_flag = instr[0];
        unique case (f)
            FMT_C: begin
                dec.reg_o = instr[0] ? 3'd3 : 3'd2;
                jmp_loc   = labels[instr[3:0]];
            end
            FMT_I: begin
                dec.reg1_i = instr[3:1];
                dec.reg_o  = instr[3:1];
                dec.reg2_i = instr[3:1] + 3'd1;   // wraps mod 8
            end
            FMT_M: begin
                // M-form jumps only reach the top quarter of the label table
                jmp_loc = labels[{2'b11, instr[1:0]}];
                if (instr[7:4] == OP_MVB) begin
                    dec.reg1_i = {1'b1, instr[1:0]};
                    dec.reg_o  = {1'b0, instr[3:2]};
                end else begin
                    dec.reg1_i = {1'b0, instr[3:2]};
                    dec.reg2_i = {1'b0, instr[3:2]} + 3'd1;
                    dec.reg_o  = {1'b1, instr[1:0]};
                end
            end
            default: ;   // X form: all register fields and jmp_loc stay 0
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction fetch with loadable memory and label table.
//   clk, reset                      clock; async active-high reset (memory not reset)
//   load_en/load_addr/load_data     program load, honoured in IDLE/HALT, addr < DEPTH
//   label_we/label_idx/label_data   label table write, any state
//   start/start_pc                  begin fetching from start_pc (IDLE/HALT only)
//   stall                           hold pc, state and outputs
//   redirect_valid/redirect_pc      flush and refetch (FETCH only, beats stall)
//   valid, pc_out, format, opcode,
//   reg1_i, reg2_i, reg_o, imm,
//   imm_flag, jmp_loc               registered decoded instruction
//   halted                          controller is in HALT
import isa_pkg::*;

module instr_fetch #(
    parameter int PC_W    = 16,
    parameter int DEPTH   = 256,
    parameter int NLABELS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [PC_W-1:0]  load_addr,
    input  logic [7:0]       load_data,
    input  logic             label_we,
    input  logic [3:0]       label_idx,
    input  logic [PC_W-1:0]  label_data,
    input  logic             start,
    input  logic [PC_W-1:0]  start_pc,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic             valid,
    output logic [PC_W-1:0]  pc_out,
    output logic [1:0]       format,
    output logic [3:0]       opcode,
    output logic [2:0]       reg1_i,
    output logic [2:0]       reg2_i,
    output logic [2:0]       reg_o,
    output logic [2:0]       imm,
    output logic             imm_flag,
    output logic [PC_W-1:0]  jmp_loc,
    output logic             halted
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e                        state, state_nxt;
    logic [PC_W-1:0]               pc;
    logic [7:0]                    mem [DEPTH];
    logic [NLABELS-1:0][PC_W-1:0]  labels;

    dec_t                          out_q, cur_dec;
    logic [PC_W-1:0]               jmp_q, cur_jmp;
    logic [7:0]                    cur_instr;
    logic                          pc_in_mem, load_ok;
    logic                          do_start, do_fetch, do_redirect;

    // Out-of-range fetches read as HALT so a runaway program stops cleanly.
    assign pc_in_mem = ({1'b0, pc} < (PC_W+1)'(DEPTH));
    assign cur_instr = pc_in_mem ? mem[pc[AW-1:0]] : HALT_INSTR;

    instr_decode #(.PC_W(PC_W), .NLABELS(NLABELS)) u_dec (
        .instr   (cur_instr),
        .labels  (labels),
        .dec     (cur_dec),
        .jmp_loc (cur_jmp)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        do_start    = 1'b0;
        do_fetch    = 1'b0;
        do_redirect = 1'b0;
        unique case (state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    do_start  = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    do_redirect = 1'b1;
                end else if (!stall) begin
                    do_fetch = 1'b1;
                    if (cur_dec.opcode == OP_HALT) state_nxt = ST_HALT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- pc and output registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= '0;
            pc_out <= '0;
            out_q  <= '0;
            jmp_q  <= '0;
            valid  <= 1'b0;
            halted <= 1'b0;
        end else begin
            halted <= (state_nxt == ST_HALT);
            // A restart from HALT drops the stale halt instruction until the
            // first new fetch lands.
            if (do_start) begin
                pc    <= start_pc;
                valid <= 1'b0;
            end
            if (do_redirect) begin
                pc    <= redirect_pc;
                valid <= 1'b0;
            end
            if (do_fetch) begin
                out_q  <= cur_dec;
                jmp_q  <= cur_jmp;
                pc_out <= pc;
                valid  <= 1'b1;
                pc     <= pc + 1'b1;
            end
        end
    end

    // Label writes land at the edge, so a same-cycle decode sees the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         labels <= '0;
        else if (label_we) labels[label_idx] <= label_data;
    end

    // ---------------- instruction memory (no reset) ----------------
    assign load_ok = load_en && (state != ST_FETCH) &&
                     ({1'b0, load_addr} < (PC_W+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (load_ok) mem[load_addr[AW-1:0]] <= load_data;
    end

    assign format   = out_q.fmt;
    assign opcode   = out_q.opcode;
    assign reg1_i   = out_q.reg1_i;
    assign reg2_i   = out_q.reg2_i;
    assign reg_o    = out_q.reg_o;
    assign imm      = out_q.imm;
    assign imm_flag = out_q.imm_flag;
    assign jmp_loc  = jmp_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [15:0] load_addr;
    logic [7:0]  load_data;
    logic        label_we;
    logic [3:0]  label_idx;
    logic [15:0] label_data;
    logic        start;
    logic [15:0] start_pc;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        valid;
    logic [15:0] pc_out;
    logic [1:0]  format;
    logic [3:0]  opcode;
    logic [2:0]  reg1_i, reg2_i, reg_o, imm;
    logic        imm_flag;
    logic [15:0] jmp_loc;
    logic        halted;

    instr_fetch dut (
        .clk(clk), .reset(reset),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .label_we(label_we), .label_idx(label_idx), .label_data(label_data),
        .start(start), .start_pc(start_pc), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .valid(valid), .pc_out(pc_out), .format(format), .opcode(opcode),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .reg_o(reg_o), .imm(imm),
        .imm_flag(imm_flag), .jmp_loc(jmp_loc), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic [1:0]  fmt;
        logic [3:0]  op;
        logic [2:0]  r1, r2, ro, im;
        logic        fl;
        logic [15:0] jmp;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] lab [16];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decode, written from the ISA tables opcode by opcode.
    function automatic exp_t ref_dec(input logic [15:0] pc, input logic [7:0] b);
        exp_t e;
        e     = '0;
        e.pc  = pc;
        e.op  = b[7:4];
        e.im  = b[3:1];
        e.fl  = b[0];
        case (b[7:4])
            4'h2, 4'h4: begin
                e.fmt = 2'b00;
                e.ro  = b[0] ? 3'd3 : 3'd2;
                e.jmp = lab[b[3:0]];
            end
            4'h9, 4'hD: begin
                e.fmt = 2'b01;
                e.r1  = b[3:1];
                e.ro  = b[3:1];
                e.r2  = (b[3:1] == 3'd7) ? 3'd0 : b[3:1] + 3'd1;
            end
            4'hE: e.fmt = 2'b11;
            4'h5: begin
                e.fmt = 2'b10;
                e.r1  = 3'd4 + {1'b0, b[1:0]};
                e.ro  = {1'b0, b[3:2]};
                e.jmp = lab[12 + b[1:0]];
            end
            default: begin
                e.fmt = 2'b10;
                e.r1  = {1'b0, b[3:2]};
                e.r2  = {1'b0, b[3:2]} + 3'd1;
                e.ro  = 3'd4 + {1'b0, b[1:0]};
                e.jmp = lab[12 + b[1:0]];
            end
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] pc, input logic [7:0] b);
        sb.push_back(ref_dec(pc, b));
    endtask

    task automatic cmp_pop(input string tag);
        exp_t e, g;
        e = sb.pop_front();
        g = {pc_out, format, opcode, reg1_i, reg2_i, reg_o, imm, imm_flag, jmp_loc};
        chk($sformatf("%s@%0d", tag, e.pc), 64'(g), 64'(e));
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
            if (valid) cmp_pop(tag);
        end
        chk({tag, "_done"}, 64'(sb.size()), 64'd0);
        chk({tag, "_halted"}, {63'd0, halted}, 64'd1);
        chk({tag, "_valid"}, {63'd0, valid}, 64'd1);
    endtask

    task automatic load(input logic [15:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic set_label(input logic [3:0] i, input logic [15:0] d);
        label_we = 1'b1; label_idx = i; label_data = d;
        tick();
        label_we = 1'b0;
        lab[i] = d;
    endtask

    task automatic do_start(input logic [15:0] a);
        start = 1'b1; start_pc = a;
        tick();
        start = 1'b0;
        chk("start_valid0", {63'd0, valid}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; load_en = 0; load_addr = 0; load_data = 0;
        label_we = 0; label_idx = 0; label_data = 0;
        start = 0; start_pc = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
        for (int i = 0; i < 16; i++) lab[i] = 16'h0;
        tick(); tick();
        chk("rst_valid",  {63'd0, valid},  64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        chk("rst_pc_out", 64'(pc_out),     64'd0);
        chk("rst_fields", 64'({format, opcode, reg1_i, reg2_i, reg_o, imm, imm_flag}), 64'd0);
        chk("rst_jmp",    64'(jmp_loc),    64'd0);
        reset = 1'b0;
        tick();

        set_label(4'd12, 16'h0040);
        set_label(4'd15, 16'h0777);
        load(16'd50, 8'h4C); load(16'd51, 8'h5B); load(16'd52, 8'hDE);
        load(16'd53, 8'h74); load(16'd54, 8'h2F); load(16'd55, 8'h9A);
        load(16'd56, 8'hE0);
        load(16'd60, 8'h13); load(16'd61, 8'hE0);
        load(16'd255, 8'h2F);

        // Straight-line program ending in HALT.
        do_start(16'd50);
        push(50, 8'h4C); push(51, 8'h5B); push(52, 8'hDE); push(53, 8'h74);
        push(54, 8'h2F); push(55, 8'h9A); push(56, 8'hE0);
        drain("runA", 20);

        // Loads are accepted while halted.
        load(16'd200, 8'h5B); load(16'd201, 8'hE0);
        chk("halt_hold", {63'd0, halted}, 64'd1);
        do_start(16'd200);
        push(200, 8'h5B); push(201, 8'hE0);
        drain("runHaltLoad", 10);

        // Stall, load attempt during FETCH, then redirect over stall.
        do_start(16'd50);
        push(50, 8'h4C);
        tick();
        chk("b_first_valid", {63'd0, valid}, 64'd1);
        cmp_pop("runB");
        stall = 1'b1;
        load_en = 1'b1; load_addr = 16'd61; load_data = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc_out", 64'(pc_out), 64'd50);
            chk("stall_fields", 64'({valid, format, opcode, reg_o, jmp_loc}),
                64'({1'b1, 2'b00, 4'h4, 3'd2, 16'h0040}));
        end
        load_en = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 16'd60;
        tick();
        redirect_valid = 1'b0; stall = 1'b0;
        chk("redirect_valid0", {63'd0, valid}, 64'd0);
        // mem[61] must still hold HALT: the FETCH-time load was dropped.
        push(60, 8'h13); push(61, 8'hE0);
        drain("runB", 10);

        // Running off the end of memory fetches HALT.
        do_start(16'd255);
        push(255, 8'h2F); push(256, 8'hE0);
        drain("runEnd", 10);

        // Label write in the same cycle as decode sees the old label.
        do_start(16'd50);
        label_we = 1'b1; label_idx = 4'd12; label_data = 16'h0099;
        push(50, 8'h4C);
        tick();
        label_we = 1'b0;
        lab[12] = 16'h0099;
        cmp_pop("lblRace");
        push(51, 8'h5B);
        tick();
        cmp_pop("lblRace");

        // Asynchronous reset between edges.
        #1 reset = 1'b1;
        #1;
        chk("arst_valid",  {63'd0, valid},  64'd0);
        chk("arst_halted", {63'd0, halted}, 64'd0);
        chk("arst_pc_out", 64'(pc_out),     64'd0);
        chk("arst_jmp",    64'(jmp_loc),    64'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) lab[i] = 16'h0;
        tick();

        // Memory survives reset; labels do not.
        do_start(16'd50);
        push(50, 8'h4C); push(51, 8'h5B); push(52, 8'hDE); push(53, 8'h74);
        push(54, 8'h2F); push(55, 8'h9A); push(56, 8'hE0);
        drain("runPostRst", 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
